// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Wide enough for any practical pipeline depth; narrower stage fields are zero-extended.
    localparam int STAGE_IDX_W = 8;
    typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HUNG  = 2'd2
    } wdog_state_e;

    // Statistics address map (base of each counter bank).
    localparam int STAT_SEL_STALL = 0;
    localparam int STAT_SEL_FLUSH = 16;
    localparam int STAT_SEL_REDIR = 32;
    localparam int STAT_SEL_HANG  = 63;

    // True when sel addresses entry idx of the bank starting at base.
    function automatic logic stat_hit(input logic [7:0] sel, input int base, input int idx);
        return (int'(sel) == (base + idx));
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Purpose: bundles stage requests, redirect requests and control outputs of the hazard unit.
// Latency: n/a (wires only).
// Backpressure: none; the controller answers every request in the same cycle.
interface pipeline_hazard_unit_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REDIR  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0]                stall_req;
    logic [NUM_STAGES-1:0]                bubble_req;
    logic [NUM_REDIR-1:0]                 redir_valid;
    logic [NUM_REDIR-1:0][SW-1:0]         redir_stage;
    logic [NUM_REDIR-1:0][ADDR_WIDTH-1:0] redir_pc;
    logic [NUM_STAGES-1:0]                stall_o;
    logic [NUM_STAGES-1:0]                flush_o;
    logic                                 load_pc_we;
    logic [ADDR_WIDTH-1:0]                load_pc_new;
    logic                                 hang_clr;
    logic                                 hang;
    logic [7:0]                           stat_sel;
    logic [CNT_WIDTH-1:0]                 stat_data;

    // Pipeline side: raises requests, consumes stall/flush/PC controls.
    modport master (
        output stall_req, bubble_req, redir_valid, redir_stage, redir_pc, hang_clr, stat_sel,
        input  stall_o, flush_o, load_pc_we, load_pc_new, hang, stat_data
    );

    // Hazard controller side.
    modport slave (
        input  stall_req, bubble_req, redir_valid, redir_stage, redir_pc, hang_clr, stat_sel,
        output stall_o, flush_o, load_pc_we, load_pc_new, hang, stat_data
    );

endinterface

// File: rtl/hazard_watchdog.sv
// Purpose: flags a sticky hang after WDOG_LIMIT consecutive cycles without WB progress.
// Latency: hang rises the cycle after the counter reaches WDOG_LIMIT; clears the cycle after hang_clr.
// Backpressure: none; observes progress only.
module hazard_watchdog
    import hazard_pkg::*;
#(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic progress_i,
    input  logic hang_clr_i,
    output logic hang_o
);
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(WDOG_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    wdog_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: count consecutive no-progress cycles, saturating; HUNG waits for hang_clr.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (!progress_i) begin
                    state_d = STALL;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            STALL: begin
                if (progress_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == LIMIT) begin
                    state_d = HUNG;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HUNG: begin
                if (hang_clr_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign hang_o = (state_q == HUNG);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Purpose: stall/bubble/redirect controller for an N-stage in-order pipeline, plus hang watchdog.
// Latency: stall/flush/load_pc are combinational (0 cycles); hang and stat_data are registered.
// Backpressure: downstream holds propagate upstream; bubbles and younger redirects wait or drop.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REDIR  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_unit_if.slave hz
);
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] down_free;
    logic                  win_vld;
    stage_idx_t            win_stage;
    logic [ADDR_WIDTH-1:0] win_pc;
    logic [NUM_REDIR-1:0]  win_sel;
    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  pc_we_c;
    logic [ADDR_WIDTH-1:0] pc_new_c;
    logic                  hang;

    // Hold chain: a stage holds if it stalls, bubbles, or anything downstream holds.
    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = hz.stall_req[NUM_STAGES-1] | hz.bubble_req[NUM_STAGES-1];
        for (int j = NUM_STAGES - 2; j >= 0; j--) begin
            hold[j] = hz.stall_req[j] | hz.bubble_req[j] | hold[j+1];
        end
    end

    // A stage may hand its instruction on when the next stage is not held; WB always can.
    assign down_free = {1'b1, ~hold[NUM_STAGES-1:1]};

    // Redirect arbiter: oldest eligible stage wins, ties go to the lowest source index.
    always_comb begin
        win_vld   = 1'b0;
        win_stage = '0;
        win_pc    = '0;
        win_sel   = '0;
        for (int i = 0; i < NUM_REDIR; i++) begin
            if (hz.redir_valid[i]
                && (int'(hz.redir_stage[i]) < NUM_STAGES)
                && down_free[hz.redir_stage[i]]
                && (!win_vld || (stage_idx_t'(hz.redir_stage[i]) > win_stage))) begin
                win_vld    = 1'b1;
                win_stage  = stage_idx_t'(hz.redir_stage[i]);
                win_pc     = hz.redir_pc[i];
                win_sel    = '0;
                win_sel[i] = 1'b1;
            end
        end
    end

    // Output controls: bubbles first, then the winning redirect flushes stages 1..k and frees
    // their registers (including the PC), and reset forces a safe pipeline-wide flush.
    always_comb begin
        stall_c  = hold;
        flush_c  = '0;
        pc_we_c  = win_vld;
        pc_new_c = win_pc;
        for (int j = 0; j < NUM_STAGES - 1; j++) begin
            flush_c[j+1] = hz.bubble_req[j] & ~hold[j+1];
        end
        if (win_vld) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (stage_idx_t'(j) <= win_stage) begin
                    stall_c[j] = 1'b0;
                    if (j != 0) begin
                        flush_c[j] = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            stall_c  = '0;
            flush_c  = {{(NUM_STAGES-1){1'b1}}, 1'b0};
            pc_we_c  = 1'b0;
            pc_new_c = '0;
        end
    end

    assign hz.stall_o     = stall_c;
    assign hz.flush_o     = flush_c;
    assign hz.load_pc_we  = pc_we_c;
    assign hz.load_pc_new = pc_new_c;

    hazard_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .progress_i (~hold[NUM_STAGES-1]),
        .hang_clr_i (hz.hang_clr),
        .hang_o     (hang)
    );

    assign hz.hang = hang;

`ifdef HAZARD_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q [NUM_STAGES];
    logic [CNT_WIDTH-1:0] flush_cnt_q [NUM_STAGES];
    logic [CNT_WIDTH-1:0] redir_cnt_q [NUM_REDIR];
    logic [CNT_WIDTH-1:0] hang_cnt_q;
    logic                 hang_prev_q;
    logic [CNT_WIDTH-1:0] stat_d, stat_q;

    // Saturating event counters; a hang event is the rising edge of the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                stall_cnt_q[j] <= '0;
                flush_cnt_q[j] <= '0;
            end
            for (int i = 0; i < NUM_REDIR; i++) begin
                redir_cnt_q[i] <= '0;
            end
            hang_cnt_q  <= '0;
            hang_prev_q <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (stall_c[j] && (stall_cnt_q[j] != '1)) stall_cnt_q[j] <= stall_cnt_q[j] + 1'b1;
                if (flush_c[j] && (flush_cnt_q[j] != '1)) flush_cnt_q[j] <= flush_cnt_q[j] + 1'b1;
            end
            for (int i = 0; i < NUM_REDIR; i++) begin
                if (win_sel[i] && (redir_cnt_q[i] != '1)) redir_cnt_q[i] <= redir_cnt_q[i] + 1'b1;
            end
            hang_prev_q <= hang;
            if (hang && !hang_prev_q && (hang_cnt_q != '1)) hang_cnt_q <= hang_cnt_q + 1'b1;
        end
    end

    // Statistic read mux; unmapped selects read zero.
    always_comb begin
        stat_d = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (stat_hit(hz.stat_sel, STAT_SEL_STALL, j)) stat_d = stall_cnt_q[j];
            if (stat_hit(hz.stat_sel, STAT_SEL_FLUSH, j)) stat_d = flush_cnt_q[j];
        end
        for (int i = 0; i < NUM_REDIR; i++) begin
            if (stat_hit(hz.stat_sel, STAT_SEL_REDIR, i)) stat_d = redir_cnt_q[i];
        end
        if (stat_hit(hz.stat_sel, STAT_SEL_HANG, 0)) stat_d = hang_cnt_q;
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign hz.stat_data = stat_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{hz.stat_sel, win_sel};
    assign hz.stat_data  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Purpose: directed self-checking bench for pipeline_hazard_unit (N=5, two redirect sources).
// Latency: inputs driven on the falling edge, outputs sampled 1-3 time units later.
// Backpressure: n/a.
module tb_pipeline_hazard_unit;
    localparam int NS = 5;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int WL = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    pipeline_hazard_unit_if #(.NUM_STAGES(NS), .NUM_REDIR(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hz ();

    pipeline_hazard_unit #(
        .NUM_STAGES (NS),
        .NUM_REDIR  (NR),
        .ADDR_WIDTH (AW),
        .WDOG_LIMIT (WL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic [4:0] st, input logic [4:0] fl,
                            input logic we, input logic [31:0] pc);
        chk({tag, ".stall_o"}, 64'(hz.stall_o), 64'(st));
        chk({tag, ".flush_o"}, 64'(hz.flush_o), 64'(fl));
        chk({tag, ".load_pc_we"}, 64'(hz.load_pc_we), 64'(we));
        chk({tag, ".load_pc_new"}, 64'(hz.load_pc_new), 64'(pc));
    endtask

    task automatic idle();
        hz.stall_req   = '0;
        hz.bubble_req  = '0;
        hz.redir_valid = '0;
        hz.redir_stage = '0;
        hz.redir_pc    = '0;
        hz.hang_clr    = 1'b0;
        hz.stat_sel    = '0;
    endtask

    task automatic redir(input int i, input logic [2:0] st, input logic [31:0] pc);
        hz.redir_valid[i] = 1'b1;
        hz.redir_stage[i] = st;
        hz.redir_pc[i]    = pc;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk_pipe("reset", 5'b00000, 5'b11110, 1'b0, 32'h0);
        chk("reset.hang", 64'(hz.hang), 64'd0);
        chk("reset.stat_data", 64'(hz.stat_data), 64'd0);
        // Requests during reset must not leak through.
        hz.stall_req = 5'b01000;
        redir(0, 3'd1, 32'h40);
        #1 chk_pipe("reset_override", 5'b00000, 5'b11110, 1'b0, 32'h0);

        @(negedge clk); idle(); rst = 1'b0;
        #1 chk_pipe("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Stage-3 stall for four cycles, then release.
        @(negedge clk); hz.stall_req = 5'b01000;
        #1 chk_pipe("stall3_c1", 5'b01111, 5'b00000, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk_pipe("stall3_cn", 5'b01111, 5'b00000, 1'b0, 32'h0);
        end
        @(negedge clk); idle();
        #1 chk_pipe("stall3_release", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Load-use bubble from decode.
        @(negedge clk); idle(); hz.bubble_req = 5'b00010;
        #1 chk_pipe("bubble1", 5'b00011, 5'b00100, 1'b0, 32'h0);

        // Bubble waits behind a downstream stall.
        @(negedge clk); idle(); hz.bubble_req = 5'b00010; hz.stall_req = 5'b01000;
        #1 chk_pipe("bubble_blocked", 5'b01111, 5'b00000, 1'b0, 32'h0);

        // Bubble request at WB only holds; there is no register after it to flush.
        @(negedge clk); idle(); hz.bubble_req = 5'b10000;
        #1 chk_pipe("bubble_wb", 5'b11111, 5'b00000, 1'b0, 32'h0);

        // Redirect from stage 1 overrides an IF stall.
        @(negedge clk); idle(); hz.stall_req = 5'b00001; redir(0, 3'd1, 32'h400);
        #1 chk_pipe("redir_if_stall", 5'b00000, 5'b00010, 1'b1, 32'h400);

        // Two redirects: the older stage wins.
        @(negedge clk); idle(); redir(0, 3'd1, 32'h100); redir(1, 3'd2, 32'h200);
        #1 chk_pipe("redir_oldest", 5'b00000, 5'b00110, 1'b1, 32'h200);

        // Same stage: lowest source index wins.
        @(negedge clk); idle(); redir(0, 3'd2, 32'h300); redir(1, 3'd2, 32'h500);
        #1 chk_pipe("redir_tie", 5'b00000, 5'b00110, 1'b1, 32'h300);

        // Redirect behind a downstream hold is not eligible.
        @(negedge clk); idle(); hz.stall_req = 5'b01000; redir(0, 3'd1, 32'h100);
        #1 chk_pipe("redir_blocked", 5'b01111, 5'b00000, 1'b0, 32'h0);

        // Redirect from WB is always eligible, even while WB stalls.
        @(negedge clk); idle(); hz.stall_req = 5'b10000; redir(0, 3'd1, 32'h100); redir(1, 3'd4, 32'h800);
        #1 chk_pipe("redir_wb", 5'b00000, 5'b11110, 1'b1, 32'h800);

        // Redirect flush overrides a bubble flush in its range.
        @(negedge clk); idle(); hz.bubble_req = 5'b00010; redir(0, 3'd3, 32'h700);
        #1 chk_pipe("redir_over_bubble", 5'b00000, 5'b01110, 1'b1, 32'h700);

        // Watchdog: let it return to RUN, then hold WB.
        @(negedge clk); idle();
        #1 chk_pipe("idle2", 5'b00000, 5'b00000, 1'b0, 32'h0);
        @(negedge clk); hz.stall_req = 5'b10000;
        repeat (8) @(negedge clk);
        #1 chk("wdog_edge8", 64'(hz.hang), 64'd0);
        @(negedge clk);
        #1 chk("wdog_edge9", 64'(hz.hang), 64'd1);
        repeat (3) @(negedge clk);
        #1 chk("wdog_sticky", 64'(hz.hang), 64'd1);
        hz.stall_req = 5'b00000; hz.hang_clr = 1'b1;
        @(negedge clk); hz.hang_clr = 1'b0;
        #1 chk("wdog_clr", 64'(hz.hang), 64'd0);

        // Progress restarts the count; hang_clr outside HUNG changes nothing.
        @(negedge clk); hz.stall_req = 5'b10000;
        repeat (5) @(negedge clk);
        hz.stall_req = 5'b00000;
        @(negedge clk); hz.stall_req = 5'b10000; hz.hang_clr = 1'b1;
        repeat (8) @(negedge clk);
        #1 chk("wdog_restart", 64'(hz.hang), 64'd0);
        @(negedge clk); hz.hang_clr = 1'b0;
        #1 chk("wdog_clr_ignored", 64'(hz.hang), 64'd1);
        @(negedge clk);
        #1 chk("wdog_sticky2", 64'(hz.hang), 64'd1);

        // Asynchronous reset mid-stall with a redirect pending.
        @(negedge clk); redir(1, 3'd4, 32'h800);
        #2 rst = 1'b1;
        #1 chk_pipe("rst_mid", 5'b00000, 5'b11110, 1'b0, 32'h0);
        chk("rst_mid.hang", 64'(hz.hang), 64'd0);
        chk("rst_mid.stat_data", 64'(hz.stat_data), 64'd0);
        @(negedge clk); idle(); rst = 1'b0;
        #1 chk_pipe("post_rst", 5'b00000, 5'b00000, 1'b0, 32'h0);
        repeat (10) @(negedge clk);
        #1 chk("post_rst.hang", 64'(hz.hang), 64'd0);

`ifdef HAZARD_STATS_EN
        begin
            logic [7:0] sels [12];
            sels = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd16, 8'd17, 8'd18, 8'd19, 8'd32, 8'd33, 8'd63};
            for (int s = 0; s < 12; s++) begin
                hz.stat_sel = sels[s];
                @(negedge clk);
                #1 chk("stat_after_rst", 64'(hz.stat_data), 64'd0);
            end
        end
`else
        hz.stat_sel = 8'd63;
        @(negedge clk);
        #1 chk("stat_disabled", 64'(hz.stat_data), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
